mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter. It is a responder on the core data-memory port: same address, store-mode, write-enable and write-data signalling the core drives into data memory.
- Top decodes it from addr; its read data is muxed into load results when hit is high.
- Buffers bytes in a FIFO and serialises them 8N1 (LSB first) on tx, so software can emit text without stalling.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 128 ++++++++++++
 tb/tb_mmio_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions, tx FSM states and funct3 width codes
package uart_pkg;
  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_PAR = 4;
  localparam int ST_CNT = 8;
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: core data-memory port (addr/mode/wen/data_i from core, data_o/hit back)
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [2:0] mode;
  logic wen;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic hit;
  modport master (output addr, mode, wen, data_i, input data_o, hit);
  modport slave (input addr, mode, wen, data_i, output data_o, hit);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; push accepted when not full or when popping
// ports: clk, rst (sync, active high), push/din, pop/dout, full, empty, push_ok, count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    do_pop = pop & ~empty;
    push_ok = push & (~full | do_pop);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    rd_d = rd_q + AW'(do_pop);
    wr_d = wr_q + AW'(push_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped FIFO-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN)
// ports: clk, rst (sync, active high), bus (data-memory port, slave), tx (serial, idle high),
//        irq (FIFO empty and transmitter idle)
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_e AFTER_DATA = PARITY;
  localparam logic PAR_FLAG = 1'b1;
  logic par_q, par_d;
`else
  localparam tx_state_e AFTER_DATA = STOP;
  localparam logic PAR_FLAG = 1'b0;
`endif
  tx_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;
  logic wr, push, pop, push_ok, full, empty, tick, unused;
  logic [7:0] fifo_dout;
  logic [CW-1:0] count;
  logic [31:0] status, rdata;
  logic [15:0] lane;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.data_i[7:0]),
    .dout(fifo_dout), .full(full), .empty(empty), .push_ok(push_ok), .count(count)
  );
  assign unused = &{1'b0, bus.data_i[31:8]};
  assign bus.hit = bus.addr[31:4] == BASE_ADDR[31:4];
  assign wr = bus.hit & bus.wen;
  assign push = wr & (bus.addr[3:2] == TXDATA_OFF);
  assign tick = baud_q == '0;
  assign tx = tx_q;
  assign irq = irq_q;
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = state_q != IDLE;
    status[ST_OVF] = ovf_q;
    status[ST_PAR] = PAR_FLAG;
    status[ST_CNT +: 8] = 8'(count);
  end
  assign rdata = bus.addr[3:2] == STATUS_OFF ? status : '0;
  assign lane = 16'(rdata >> {bus.addr[1:0], 3'b000});
  assign bus.data_o = !bus.hit ? '0 :
    bus.mode == F3_B ? {{24{lane[7]}}, lane[7:0]} :
    bus.mode == F3_BU ? {24'b0, lane[7:0]} :
    bus.mode == F3_H ? {{16{lane[15]}}, lane} :
    bus.mode == F3_HU ? {16'b0, lane} : rdata;
  always_comb begin
    ovf_d = ovf_q;
    if (wr && bus.addr[3:2] == STATUS_OFF && bus.data_i[ST_OVF]) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    baud_d = state_q == IDLE ? baud_q : tick ? BAUD_MAX : baud_q - 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_d = fifo_dout;
        baud_d = BAUD_MAX;
        bit_d = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = AFTER_DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // line and irq are registered from the current state, so they trail it by one clock
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    irq_d = state_q == IDLE && empty;
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^fifo_dout : par_q;
    if (state_q == PARITY) tx_d = par_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      irq_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      irq_q <= irq_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized self-checking bench with line decoder and queue model
module tb_mmio_uart_tx;
  import uart_pkg::*;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;
  localparam int FR = NB * DIV;
  localparam logic [31:0] BASE = 32'h0001_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  bit rx_ok[$];
  logic [7:0] mb;
  bit mok;
  mmio_uart_tx_if bus();
  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0) begin
      repeat (DIV / 2) @(negedge clk);
      mok = tx === 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clk);
        mb[k] = tx;
      end
      if (PAR != 0) begin
        repeat (DIV) @(negedge clk);
        mok = mok && (tx === ^mb);
      end
      repeat (DIV) @(negedge clk);
      mok = mok && (tx === 1'b1);
      rx_q.push_back(mb);
      rx_ok.push_back(mok);
    end
  end
  function automatic logic [31:0] st(input int cnt, input bit busy, input bit ovf);
    return {16'b0, 8'(cnt), 3'b0, 1'(PAR), ovf, busy, cnt == 0, cnt == DEPTH};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    bus.addr = a;
    bus.data_i = d;
    bus.mode = m;
    bus.wen = 1'b1;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    bus.addr = '0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [2:0] m, output logic [31:0] d, output logic h);
    bus.addr = a;
    bus.mode = m;
    bus.wen = 1'b0;
    #1;
    d = bus.data_o;
    h = bus.hit;
    bus.addr = '0;
  endtask
  task automatic wait_idle(output bit ok);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (irq !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    ok = irq === 1'b1;
    tick(4);
  endtask
  task automatic test_reset;
    logic [31:0] d;
    logic h;
    rst = 1'b1;
    bus.wen = 1'b0;
    bus.addr = '0;
    bus.mode = F3_W;
    bus.data_i = '0;
    tick(3);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", irq); end
    rst = 1'b0;
    tick(1);
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(0, 0, 0) || h !== 1'b1) begin
      errors++; $display("FAIL reset_status got %h/%b want %h/1", d, h, st(0, 0, 0));
    end
  endtask
  task automatic test_single_frame(input logic [7:0] b);
    logic exp;
    rx_q.delete();
    rx_ok.delete();
    wr(BASE, {24'h0, b}, F3_W);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL lat0 got %b want 1", tx); end
    tick(1);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL lat1 got %b want 1", tx); end
    tick(1);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL lat2_start got %b want 0", tx); end
    tick(DIV / 2);
    for (int i = 0; i < NB; i++) begin
      if (i > 0) tick(DIV);
      exp = i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (PAR != 0 && i == 9) ? ^b : 1'b1;
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL frame_%h bit%0d got %b want %b", b, i, tx, exp); end
    end
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_return got %b want 1", irq); end
    tick(4);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b || !rx_ok[0]) begin
      errors++; $display("FAIL single_rx got %0d frames want 1 frame of %h", rx_q.size(), b);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] d;
    logic h;
    bit ok;
    logic [7:0] exp[$];
    rx_q.delete();
    rx_ok.delete();
    exp = '{8'h41, 8'h42};
    wr(BASE, 32'h41, F3_W);
    wr(BASE, 32'h42, F3_B);
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(1, 1, 0)) begin errors++; $display("FAIL b2b_status got %h want %h", d, st(1, 1, 0)); end
    tick(1);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start1 got %b want 0", tx); end
    tick(FR - 1);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL b2b_stop got %b want 1", tx); end
    tick(1);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL b2b_gap got %b want 1", tx); end
    tick(1);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start2 got %b want 0", tx); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain got busy want idle"); end
    checks++;
    if (rx_q.size() != exp.size()) begin errors++; $display("FAIL b2b_rx_count got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i] || !rx_ok[i]) begin errors++; $display("FAIL b2b_rx%0d got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask
  task automatic test_overflow;
    logic [31:0] d;
    logic h;
    bit ok;
    logic [7:0] b;
    logic [7:0] exp[$];
    int cnt = 0;
    rx_q.delete();
    rx_ok.delete();
    b = 8'($urandom);
    exp.push_back(b);
    wr(BASE, {24'h0, b}, F3_W);
    tick(1);
    rd(BASE + 4, F3_B, d, h);
    checks++;
    if (d !== {24'h0, st(0, 1, 0)[7:0]}) begin errors++; $display("FAIL busy_empty_lb got %h want %h", d, st(0, 1, 0)[7:0]); end
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      wr(BASE, {24'h0, b}, F3_W);
      if (cnt < DEPTH) begin
        exp.push_back(b);
        cnt++;
      end
    end
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(cnt, 1, 1)) begin errors++; $display("FAIL ovf_status got %h want %h", d, st(cnt, 1, 1)); end
    wr(BASE + 4, 32'h8, F3_W);
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(cnt, 1, 0)) begin errors++; $display("FAIL ovf_clear got %h want %h", d, st(cnt, 1, 0)); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_drain got busy want idle"); end
    checks++;
    if (rx_q.size() != exp.size()) begin errors++; $display("FAIL ovf_rx_count got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i] || !rx_ok[i]) begin errors++; $display("FAIL ovf_rx%0d got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask
  task automatic test_reads;
    logic [31:0] d;
    logic h;
    bit ok;
    logic [7:0] exp[$];
    rx_q.delete();
    rx_ok.delete();
    for (int i = 0; i < 3; i++) exp.push_back(8'($urandom));
    wr(BASE, {24'h0, exp[0]}, F3_W);
    tick(1);
    wr(BASE, {24'h0, exp[1]}, F3_H);
    wr(BASE, {24'h0, exp[2]}, F3_B);
    rd(BASE + 5, F3_B, d, h);
    checks++;
    if (d !== 32'h2 || h !== 1'b1) begin errors++; $display("FAIL lb_count got %h/%b want 2/1", d, h); end
    rd(BASE + 5, F3_BU, d, h);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL lbu_count got %h want 2", d); end
    rd(BASE + 4, F3_HU, d, h);
    checks++;
    if (d !== {16'h0, st(2, 1, 0)[15:0]}) begin errors++; $display("FAIL lhu_status got %h want %h", d, st(2, 1, 0)[15:0]); end
    rd(BASE + 6, F3_H, d, h);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL lh_upper got %h want 0", d); end
    rd(BASE + 8, F3_W, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL lw_rsvd got %h/%b want 0/1", d, h); end
    rd(BASE, F3_W, d, h);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL lw_txdata got %h want 0", d); end
    rd(BASE + 32'h10, F3_W, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL lw_miss got %h/%b want 0/0", d, h); end
    rd(BASE - 4, F3_W, d, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL miss_below got %b want 0", h); end
    wr(BASE + 8, 32'hFF, F3_W);
    wr(BASE + 32'h10, 32'h55, F3_W);
    wr(BASE - 32'h10, 32'h66, F3_B);
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(2, 1, 0)) begin errors++; $display("FAIL ignored_writes got %h want %h", d, st(2, 1, 0)); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reads_drain got busy want idle"); end
    checks++;
    if (rx_q.size() != exp.size()) begin errors++; $display("FAIL reads_rx_count got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i] || !rx_ok[i]) begin errors++; $display("FAIL reads_rx%0d got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask
  task automatic test_mid_reset;
    logic [31:0] d;
    logic h;
    logic [7:0] b;
    int edges = 0;
    b = 8'($urandom);
    wr(BASE, {24'h0, b}, F3_W);
    tick(18);
    checks++;
    if (tx !== b[3]) begin errors++; $display("FAIL pre_reset_bit3 got %b want %b", tx, b[3]); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL midrst_line got tx=%b irq=%b want 1/1", tx, irq); end
    rd(BASE + 4, F3_W, d, h);
    checks++;
    if (d !== st(0, 0, 0)) begin errors++; $display("FAIL midrst_status got %h want %h", d, st(0, 0, 0)); end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (tx !== 1'b1) edges++;
    end
    checks++;
    if (edges != 0) begin errors++; $display("FAIL midrst_quiet got %0d low cycles want 0", edges); end
    rx_q.delete();
    rx_ok.delete();
  endtask
  task automatic test_random;
    logic [31:0] d;
    logic h;
    bit ok;
    logic [7:0] b;
    logic [2:0] m;
    logic [7:0] exp[$];
    int n;
    for (int r = 0; r < 6; r++) begin
      rx_q.delete();
      rx_ok.delete();
      exp.delete();
      n = $urandom_range(1, 7);
      // from idle, the first byte leaves the FIFO the cycle after it lands, so DEPTH+1 fit
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        m = $urandom_range(0, 2) == 0 ? F3_B : $urandom_range(0, 1) == 0 ? F3_H : F3_W;
        wr(BASE + 32'($urandom_range(0, 3)), {24'($urandom), b}, m);
        if (i < DEPTH + 1) exp.push_back(b);
      end
      rd(BASE + 4, F3_W, d, h);
      checks++;
      if (d[3] !== (n > DEPTH + 1)) begin errors++; $display("FAIL rnd%0d_ovf got %b want %b", r, d[3], n > DEPTH + 1); end
      wr(BASE + 4, 32'h8, F3_W);
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_drain got busy want idle", r); end
      checks++;
      if (rx_q.size() != exp.size()) begin errors++; $display("FAIL rnd%0d_rx_count got %0d want %0d", r, rx_q.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp[i] || !rx_ok[i]) begin errors++; $display("FAIL rnd%0d_rx%0d got %h want %h", r, i, rx_q[i], exp[i]); end
      end
      tick($urandom_range(0, 5));
    end
  endtask
  initial begin
    test_reset;
    test_single_frame(8'hA5);
    test_single_frame(8'h07);
    test_back_to_back;
    test_overflow;
    test_reads;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
